if_id_fetch_buffer: RTL and testbench
=====================================

Name: if_id_fetch_buffer

Overview:
Decoupling FIFO between the instruction-memory fetch port and the ID stage of the RV32IM pipeline. It captures {PC, instruction} pairs from fetch and presents the oldest pair to decode, where the immediate generator and decoder consume it. It absorbs ID-stage stalls and discards wrong-path instructions on a branch/jump flush. When empty, it presents a NOP bubble.

Parameters:
DEPTH, 2, number of {PC, instruction} entries; power of two, minimum 2
NOP_INSTR, 32'h00000013, instruction driven to ID when no valid entry (ADDI x0,x0,0)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
IMEM_VALID  input  1  fetch side presents a valid PC/instruction pair this cycle
IMEM_PC  input  32  PC of the fetched instruction
IMEM_INSTR  input  32  fetched instruction word
IMEM_READY  output  1  buffer accepts a push this cycle
ID_STALL  input  1  ID stage cannot consume this cycle (hazard unit)
FLUSH  input  1  discard all held and incoming entries (taken branch/jump from EX)
ID_VALID  output  1  head entry valid
ID_PC  output  32  head entry PC
ID_INSTRUCTION  output  32  head entry instruction (feeds immediate generator INSTRUCTION)
COUNT  output  clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async, RESET=1): write pointer, read pointer and COUNT go to 0. ID_VALID=0, ID_PC=0, ID_INSTRUCTION=NOP_INSTR, IMEM_READY=1. Storage contents are don't-care.
- Push = IMEM_VALID & IMEM_READY & ~FLUSH. Pop = ID_VALID & ~ID_STALL & ~FLUSH.
- IMEM_READY = (COUNT != DEPTH). Combinational from COUNT only; it has no dependency on ID_STALL or on a pop in the same cycle, so there is no pass-through when full.
- A push writes {IMEM_PC, IMEM_INSTR} at the write pointer, and the write pointer increments modulo DEPTH.
- A pop advances the read pointer modulo DEPTH.
- COUNT: push only gives +1; pop only gives −1; push and pop together leave COUNT unchanged; neither leaves it unchanged.
- Latency: an entry pushed on edge N is visible on ID_* after edge N, with ID_VALID high in cycle N+1. There is no combinational bypass from IMEM_* to ID_*.
- Head outputs are combinational from storage at the read pointer:
  - ID_VALID = (COUNT != 0).
  - When ID_VALID=0, ID_INSTRUCTION = NOP_INSTR and ID_PC = 0.
- ID_STALL=1 with ID_VALID=1: the head and all ID_* outputs hold unchanged. Pushes continue while not full.
- FLUSH=1 (synchronous, highest priority after reset): on the edge, the pointers and COUNT clear to 0, and any concurrent push or pop is discarded. ID_VALID reads 0 in the following cycle. A push in the cycle after FLUSH is accepted normally.
- Push attempted while full (IMEM_VALID=1, IMEM_READY=0): ignored, with no state change. Fetch must hold its request.
- Pop attempted while empty cannot occur, because pop is gated by ID_VALID.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by COUNT, not by pointer equality.
- Reset asserted mid-operation: all entries are lost immediately, with no completion of an in-flight push.

Test Plan:
- Reset, then idle → ID_VALID=0, ID_INSTRUCTION=32'h00000013, ID_PC=0, COUNT=0, IMEM_READY=1.
- Push PC=0x100 / 0x00500093 at edge N with ID_STALL=0 → cycle N+1: ID_VALID=1, ID_PC=0x100, ID_INSTRUCTION=0x00500093. Popped at edge N+1 → COUNT=0 after.
- ID_STALL=1, push 0x200, 0x204, 0x208 on consecutive cycles (DEPTH=2) → COUNT=2, IMEM_READY=0, and 0x208 is not accepted until a pop. Release stall → 0x200 then 0x204 are presented in order.
- COUNT=1 with simultaneous push and pop over 6 cycles (pointer wrap) → COUNT stays 1, PCs are presented in push order, with no loss or duplication.
- COUNT=2 with FLUSH=1 and IMEM_VALID=1 (PC 0x300) in the same cycle → next cycle COUNT=0, ID_VALID=0, NOP presented. Push 0x400 in the next cycle → presented one cycle later.
- Assert RESET asynchronously between edges with COUNT=2 → outputs go to reset values immediately, without waiting for CLK.

Source files
------------

// File: rtl/if_id_fetch_buffer_if.sv
// if_id_fetch_buffer_if: fetch-to-decode handshake bundle.
// Carries the fetch push port (IMEM_*) and the ID head port (ID_*),
// plus the hazard/flush controls and the occupancy count.
// slave  : buffer side (consumes IMEM_*, FLUSH, ID_STALL; drives ID_*)
// master : pipeline side (drives IMEM_*, FLUSH, ID_STALL; sees ID_*)
interface if_id_fetch_buffer_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          IMEM_VALID;
    logic [31:0]   IMEM_PC;
    logic [31:0]   IMEM_INSTR;
    logic          IMEM_READY;
    logic          ID_STALL;
    logic          FLUSH;
    logic          ID_VALID;
    logic [31:0]   ID_PC;
    logic [31:0]   ID_INSTRUCTION;
    logic [CW-1:0] COUNT;

    modport slave (
        input  IMEM_VALID, IMEM_PC, IMEM_INSTR,
        input  ID_STALL, FLUSH,
        output IMEM_READY, ID_VALID, ID_PC,
        output ID_INSTRUCTION, COUNT
    );

    modport master (
        output IMEM_VALID, IMEM_PC, IMEM_INSTR,
        output ID_STALL, FLUSH,
        input  IMEM_READY, ID_VALID, ID_PC,
        input  ID_INSTRUCTION, COUNT
    );
endinterface

// File: rtl/if_id_fetch_buffer.sv
// if_id_fetch_buffer: FIFO of {PC, instr} between fetch and ID.
// Ports: CLK, RESET (async, active-high), bus (slave modport) with
// IMEM_VALID/PC/INSTR/READY push side, ID_VALID/PC/INSTRUCTION head,
// ID_STALL, FLUSH and COUNT. Empty buffer presents NOP_INSTR, PC 0.
module if_id_fetch_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                        CLK,
    input  logic                        RESET,
    if_id_fetch_buffer_if.slave         bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Ready depends only on occupancy: no pass-through when full.
    assign w_ready = (r_count != CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_push  = bus.IMEM_VALID & w_ready & ~bus.FLUSH;
    assign w_pop   = w_valid & ~bus.ID_STALL & ~bus.FLUSH;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.FLUSH) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_pc[r_wptr]    <= bus.IMEM_PC;
            r_instr[r_wptr] <= bus.IMEM_INSTR;
        end
    end

    assign bus.IMEM_READY     = w_ready;
    assign bus.ID_VALID       = w_valid;
    assign bus.ID_PC          = w_valid ? r_pc[r_rptr] : 32'h0;
    assign bus.ID_INSTRUCTION = w_valid ? r_instr[r_rptr] : NOP_INSTR;
    assign bus.COUNT          = r_count;
endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// tb_if_id_fetch_buffer: directed checks of the IF/ID fetch buffer.
// Drives fetch/ID controls and checks head, count and ready.
module tb_if_id_fetch_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    if_id_fetch_buffer_if #(.DEPTH(2)) bus ();

    if_id_fetch_buffer #(
        .DEPTH     (2),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic st, input logic fl);
        bus.IMEM_VALID = v;
        bus.IMEM_PC    = pc;
        bus.IMEM_INSTR = pc ^ 32'hA5000000;
        bus.ID_STALL   = st;
        bus.FLUSH      = fl;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12 rst = 1'b0;
        step();
        chk("rst_valid", 32'(bus.ID_VALID), 32'd0);
        chk("rst_instr", bus.ID_INSTRUCTION, 32'h00000013);
        chk("rst_pc", bus.ID_PC, 32'h0);
        chk("rst_count", 32'(bus.COUNT), 32'd0);
        chk("rst_ready", 32'(bus.IMEM_READY), 32'd1);

        // single push then pop
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        bus.IMEM_INSTR = 32'h00500093;
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("p1_valid", 32'(bus.ID_VALID), 32'd1);
        chk("p1_pc", bus.ID_PC, 32'h100);
        chk("p1_instr", bus.ID_INSTRUCTION, 32'h00500093);
        chk("p1_count", 32'(bus.COUNT), 32'd1);
        step();
        chk("p1_pop_count", 32'(bus.COUNT), 32'd0);
        chk("p1_pop_valid", 32'(bus.ID_VALID), 32'd0);

        // stall fills the buffer, third push blocked
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        step();
        chk("st_count1", 32'(bus.COUNT), 32'd1);
        drive(1'b1, 32'h204, 1'b1, 1'b0);
        step();
        chk("st_count2", 32'(bus.COUNT), 32'd2);
        chk("st_ready", 32'(bus.IMEM_READY), 32'd0);
        drive(1'b1, 32'h208, 1'b1, 1'b0);
        step();
        chk("st_full_count", 32'(bus.COUNT), 32'd2);
        chk("st_head", bus.ID_PC, 32'h200);
        chk("st_head_ins", bus.ID_INSTRUCTION, 32'h200 ^ 32'hA5000000);
        drive(1'b1, 32'h208, 1'b0, 1'b0);
        step();
        chk("rel_head1", bus.ID_PC, 32'h204);
        chk("rel_count1", 32'(bus.COUNT), 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rel_head2", bus.ID_PC, 32'h208);
        chk("rel_count2", 32'(bus.COUNT), 32'd1);
        step();
        chk("rel_empty", 32'(bus.COUNT), 32'd0);

        // steady push+pop across pointer wrap
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        step();
        chk("wr_head0", bus.ID_PC, 32'h500);
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            step();
            chk("wr_count", 32'(bus.COUNT), 32'd1);
            chk("wr_head", bus.ID_PC, 32'h500 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("wr_empty", 32'(bus.COUNT), 32'd0);

        // flush with concurrent push
        drive(1'b1, 32'h600, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h604, 1'b1, 1'b0);
        step();
        chk("fl_pre_count", 32'(bus.COUNT), 32'd2);
        drive(1'b1, 32'h300, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        chk("fl_count", 32'(bus.COUNT), 32'd0);
        chk("fl_valid", 32'(bus.ID_VALID), 32'd0);
        chk("fl_instr", bus.ID_INSTRUCTION, 32'h00000013);
        chk("fl_pc", bus.ID_PC, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fl_post_count", 32'(bus.COUNT), 32'd1);
        chk("fl_post_pc", bus.ID_PC, 32'h400);
        step();
        chk("fl_post_empty", 32'(bus.COUNT), 32'd0);

        // async reset between edges while full
        drive(1'b1, 32'h700, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h704, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ar_pre_count", 32'(bus.COUNT), 32'd2);
        #3 rst = 1'b1;
        #1;
        chk("ar_count", 32'(bus.COUNT), 32'd0);
        chk("ar_valid", 32'(bus.ID_VALID), 32'd0);
        chk("ar_ready", 32'(bus.IMEM_READY), 32'd1);
        chk("ar_instr", bus.ID_INSTRUCTION, 32'h00000013);
        chk("ar_pc", bus.ID_PC, 32'h0);
        #10 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
